// File: rtl/serial_adder_nbit.sv
// -----------------------------------------------------------------------------
// serial_adder_nbit
//
// Multi-cycle adder computing {Cout, S} = A + B + Cin over WIDTH bits. The sum
// is formed DIGIT bits per clock through a single DIGIT-wide ripple slice, with
// the carry held in a register between digits. One operation takes
// N = WIDTH/DIGIT working cycles followed by a one-cycle DONE state, so a
// controller that holds start high gets one result every N+1 cycles.
//
// Handshake: start is only looked at while the adder is ready (IDLE or DONE).
// A start seen on such an edge captures A/B/Cin and enters RUN; any start
// during RUN is ignored. done is a one-cycle pulse in the cycle after the
// completing edge. busy is high exactly while in RUN.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset (overrides start)
//   start        in   1      launch request, sampled only when ready
//   A, B         in   WIDTH  operands, captured on the accepting edge
//   Cin          in   1      carry-in, captured on the accepting edge
//   busy         out  1      high while the operation is running
//   done         out  1      one-cycle pulse, S/Cout/Ovf valid
//   S            out  WIDTH  sum; only meaningful from done onwards
//   Cout         out  1      carry out of bit WIDTH-1 (unsigned overflow)
//   Ovf          out  1      two's-complement overflow
//   dbg_state_o  out  2      current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic [1:0]       dbg_state_o
);

    // Reject parameter combinations the datapath cannot represent.
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_nbit: illegal WIDTH/DIGIT combination");
    end

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Datapath helpers
    logic [DIGIT:0]     sum_slice;   // {carry out, DIGIT sum bits}
    logic [WIDTH-1:0]   digit_ext;   // sum digit zero-extended to WIDTH
    logic               last_digit;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // One DIGIT-wide ripple slice over the low digit of the operand regs.
        sum_slice = {1'b0, a_q[DIGIT-1:0]}
                  + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};

        digit_ext              = '0;
        digit_ext[DIGIT-1:0]   = sum_slice[DIGIT-1:0];

        last_digit = (cnt_q == CNT_W'(N - 1));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Low digits are consumed first, so each new sum digit enters
                // at the MSB end; after N shifts digit 0 sits at bit 0.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = (s_q >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
                carry_d = sum_slice[DIGIT];
                if (last_digit) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    cout_d  = sum_slice[DIGIT];
                    // Carry into the MSB equals a^b^s at that bit, so
                    // (carry in) ^ (carry out) collapses to this XOR chain.
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1]
                            ^ sum_slice[DIGIT-1] ^ sum_slice[DIGIT];
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign S           = s_q;
    assign Cout        = cout_q;
    assign Ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule
